// File: rtl/mac_array_rq.sv
// N-lane signed MAC array with a three-stage requantization pipeline (MUL -> SHIFT -> SAT).
// Optional quantized ReLU after saturation when MAC_RELU_EN is defined.
module mac_array_rq #(
    parameter int LANES = 28,
    parameter int IN_W  = 8,
    parameter int ACC_W = 32,
    parameter int M_W   = 16,
    parameter int OUT_W = 8
) (
    input  logic                     clk,
    input  logic                     main_rst,
    input  logic                     mac_clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*IN_W-1:0]    a_flat,
    input  logic [LANES*IN_W-1:0]    b_flat,
    output logic [LANES*ACC_W-1:0]   acc_flat,
    input  logic                     rescale_start,
    input  logic [M_W-1:0]           m_scale,
    input  logic [5:0]               s_shift,
    input  logic [OUT_W-1:0]         zero_pt,
    output logic                     busy,
    output logic                     q_valid,
    output logic [LANES*OUT_W-1:0]   q_flat
);

    localparam int PR_W = 2 * IN_W;
    localparam int P_W  = ACC_W + M_W + 1;
    // Headroom for the rounding constant, which reaches 2^62 at S=63.
    localparam int R_W  = ((P_W > 63) ? P_W : 63) + 2;
    localparam int V_W  = R_W + 1;

    localparam logic signed [V_W-1:0] Q_MAX = V_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [V_W-1:0] Q_MIN = -Q_MAX - V_W'(1);

    typedef enum logic [1:0] {IDLE, MUL, SHIFT, SAT} state_t;

    state_t                   state;
    logic                     accept;
    logic                     start;
    logic signed [PR_W-1:0]   mul_w   [LANES];
    logic signed [ACC_W-1:0]  acc     [LANES];
    logic signed [ACC_W-1:0]  acc_nxt [LANES];
    logic signed [ACC_W-1:0]  snap_p0 [LANES];
    logic signed [P_W-1:0]    prod_p1 [LANES];
    logic signed [OUT_W-1:0]  q_nxt   [LANES];
    logic signed [OUT_W-1:0]  q_reg   [LANES];
    logic [M_W-1:0]           m_p0;
    logic [5:0]               s_p0;
    logic signed [OUT_W-1:0]  z_p0;

    function automatic logic signed [R_W-1:0] round_shift(
        input logic signed [P_W-1:0] p,
        input logic [5:0]            s
    );
        logic signed [R_W-1:0] pe;
        logic signed [R_W-1:0] half;
        pe   = R_W'(p);
        half = (s == 6'd0) ? '0 : (R_W'(1) << (s - 6'd1));
        return (pe + half) >>> s;
    endfunction

    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [V_W-1:0] v);
        if (v > Q_MAX)
            return OUT_W'(Q_MAX);
        else if (v < Q_MIN)
            return OUT_W'(Q_MIN);
        else
            return OUT_W'(v);
    endfunction

    function automatic logic signed [OUT_W-1:0] requant(
        input logic signed [P_W-1:0]   p,
        input logic [5:0]              s,
        input logic signed [OUT_W-1:0] z
    );
        logic signed [V_W-1:0]   v;
        logic signed [OUT_W-1:0] q;
        v = V_W'(round_shift(p, s)) + V_W'(z);
        q = saturate(v);
`ifdef MAC_RELU_EN
        if (q < z)
            q = z;
`endif
        return q;
    endfunction

    assign in_ready = !busy && !mac_clr;
    assign accept   = in_valid && in_ready;
    assign start    = rescale_start && (state == IDLE);

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            mul_w[i]   = PR_W'($signed(a_flat[i*IN_W +: IN_W])) *
                         PR_W'($signed(b_flat[i*IN_W +: IN_W]));
            acc_nxt[i] = accept ? (acc[i] + ACC_W'(mul_w[i])) : acc[i];
            q_nxt[i]   = requant(prod_p1[i], s_p0, z_p0);
        end
    end

    // Stage p0: snapshot (includes a beat accepted alongside the start); stage p1: scale product.
    always_ff @(posedge clk) begin
        if (start)
            snap_p0 <= acc_nxt;
        if (state == MUL) begin
            for (int i = 0; i < LANES; i++)
                prod_p1[i] <= P_W'(snap_p0[i]) * P_W'($signed({1'b0, m_p0}));
        end
    end

    always_ff @(posedge clk or posedge main_rst) begin
        if (main_rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            q_valid <= 1'b0;
            m_p0    <= '0;
            s_p0    <= '0;
            z_p0    <= '0;
            for (int i = 0; i < LANES; i++) begin
                acc[i]   <= '0;
                q_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++)
                acc[i] <= mac_clr ? '0 : acc_nxt[i];
            q_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rescale_start) begin
                        state <= MUL;
                        busy  <= 1'b1;
                        m_p0  <= m_scale;
                        s_p0  <= s_shift;
                        z_p0  <= $signed(zero_pt);
                    end
                end
                MUL: state <= SHIFT;
                // Stage p2: output registered on leaving SHIFT so q_valid is high during SAT.
                SHIFT: begin
                    state   <= SAT;
                    q_valid <= 1'b1;
                    q_reg   <= q_nxt;
                end
                SAT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_flat
        assign acc_flat[i*ACC_W +: ACC_W] = acc[i];
        assign q_flat[i*OUT_W +: OUT_W]   = q_reg[i];
    end

endmodule
